// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier, one multiplier bit per clock.
// Signed operands are reduced to magnitudes on accept and the sign is reapplied to the final product.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   out_q, out_d;

  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       upper_sum;
  logic [2*WIDTH:0]     acc_sum;
  logic [2*WIDTH:0]     acc_shifted;
  logic [2*WIDTH-1:0]   product;
  logic                 last;

  // Datapath: magnitudes on accept, one add-and-shift step per CALC cycle.
  always_comb begin
    // Most negative value maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    mag1        = (signed_mode && in1[WIDTH-1]) ? -in1 : in1;
    mag2        = (signed_mode && in2[WIDTH-1]) ? -in2 : in2;
    upper_sum   = acc_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_sum     = {upper_sum, acc_q[WIDTH-1:0]};
    acc_shifted = acc_sum >> 1;
    product     = acc_shifted[2*WIDTH-1:0];
    last        = (count_q == CW'(WIDTH - 1));
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d  = mag1;
          mplier_d = mag2;
          neg_d    = signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        acc_d    = acc_shifted;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (last) begin
          out_d   = neg_q ? -product : product;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      out_q    <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=8 and WIDTH=4.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [7:0]  in1, in2;
  logic [15:0] out;

  logic        n_in_valid, n_in_ready, n_signed_mode, n_out_valid, n_out_ready;
  logic [3:0]  n_in1, n_in2;
  logic [7:0]  n_out;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .in1(n_in1),
    .in2(n_in2), .signed_mode(n_signed_mode), .out_valid(n_out_valid),
    .out_ready(n_out_ready), .out(n_out)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge where out_valid is seen.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                     output logic [15:0] res, output int lat);
    in1 = a; in2 = b; signed_mode = sm; in_valid = 1'b1;
    chk("op8_in_ready", in_ready, 1);
    @(negedge clk);
    // Disturb inputs after accept: they must not matter any more.
    in_valid = 1'b0; in1 = ~a; in2 = ~b; signed_mode = ~sm;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = out;
  endtask

  task automatic consume8();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("consume_out_valid", out_valid, 0);
    chk("consume_in_ready", in_ready, 1);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                     output logic [7:0] res, output int lat);
    n_in1 = a; n_in2 = b; n_signed_mode = sm; n_in_valid = 1'b1;
    @(negedge clk);
    n_in_valid = 1'b0; n_signed_mode = ~sm;
    lat = 0;
    while (!n_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = n_out;
    n_out_ready = 1'b1;
    @(negedge clk);
    n_out_ready = 1'b0;
    chk("w4_consume", n_out_valid, 0);
  endtask

  initial begin
    logic [15:0] res;
    logic [7:0]  res4;
    int          lat;
    logic [15:0] q[$];
    logic [15:0] e;
    int          issued, got, cyc, last_acc, sa, sb, p;
    logic [7:0]  ra, rb;
    logic        rsm;

    vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1] = '{8'h00, 8'd200, 1'b0, 16'h0000};
    vecs[2] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[3] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
    vecs[4] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 16'h4000};
    vecs[6] = '{8'hFD, 8'h05, 1'b0, 16'h04F1};
    vecs[7] = '{8'h01, 8'hFF, 1'b1, 16'hFFFF};
    vecs[8] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
    vecs[9] = '{8'd200, 8'd3, 1'b0, 16'h0258};

    rst = 1'b1;
    in_valid = 0; in1 = 0; in2 = 0; signed_mode = 0; out_ready = 0;
    n_in_valid = 0; n_in1 = 0; n_in2 = 0; n_signed_mode = 0; n_out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_w4_in_ready", n_in_ready, 1);
    chk("rst_w4_out", n_out, 0);

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].sm, res, lat);
      chk($sformatf("vec%0d_out", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, 8);
      consume8();
    end

    // Backpressure in DONE: output held, in_valid pulses ignored.
    op8(8'h12, 8'h34, 1'b0, res, lat);
    chk("bp_out", res, 16'h03A8);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); in1 = 8'hFF; in2 = 8'hFF;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_stable", out, 16'h03A8);
    end
    // Consume with new operands presented: not accepted until IDLE.
    in_valid = 1'b1; in1 = 8'd2; in2 = 8'd3; signed_mode = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("sim_out_valid", out_valid, 0);
    chk("sim_in_ready", in_ready, 1);
    chk("sim_out_kept", out, 16'h03A8);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sim_accepted", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("sim_lat", lat, 8);
    chk("sim_out", out, 16'h0006);
    consume8();

    // Reset during the third CALC cycle of 200*3.
    in1 = 8'd200; in2 = 8'd3; signed_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out", out, 0);
    repeat (12) @(negedge clk);
    chk("abort_no_result", out_valid, 0);
    op8(8'd7, 8'd6, 1'b0, res, lat);
    chk("after_abort_out", res, 16'h002A);
    chk("after_abort_lat", lat, 8);
    consume8();

    // WIDTH=4 instance.
    op4(4'hF, 4'hF, 1'b0, res4, lat);
    chk("w4_u_out", res4, 8'hE1);
    chk("w4_u_lat", lat, 4);
    op4(4'h8, 4'h7, 1'b1, res4, lat);
    chk("w4_s_out", res4, 8'hC8);
    chk("w4_s_lat", lat, 4);

    // Back-to-back random ops with out_ready tied high.
    out_ready = 1'b1;
    issued = 0; got = 0; cyc = 0; last_acc = 0;
    while (got < 1000 && cyc < 12000) begin
      if (out_valid) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rand_out", out, e);
        end else begin
          chk("rand_unexpected_out", 1, 0);
        end
        got++;
      end
      if (in_ready && issued < 1000) begin
        if (issued > 0) chk("rand_spacing", cyc - last_acc, 10);
        last_acc = cyc;
        ra = 8'($urandom); rb = 8'($urandom); rsm = 1'($urandom_range(0, 1));
        sa = rsm ? int'($signed(ra)) : int'(ra);
        sb = rsm ? int'($signed(rb)) : int'(rb);
        p = sa * sb;
        q.push_back(p[15:0]);
        in1 = ra; in2 = rb; signed_mode = rsm; in_valid = 1'b1;
        issued++;
      end else if (issued >= 1000) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rand_count", got, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
